// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment constants and the BCD digit encoder
// for the common-anode display bank (active-low segments, dp off).
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    function automatic logic [7:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    seg_enc = 8'hC0;
            4'd1:    seg_enc = 8'hF9;
            4'd2:    seg_enc = 8'hA4;
            4'd3:    seg_enc = 8'hB0;
            4'd4:    seg_enc = 8'h99;
            4'd5:    seg_enc = 8'h92;
            4'd6:    seg_enc = 8'h82;
            4'd7:    seg_enc = 8'hF8;
            4'd8:    seg_enc = 8'h80;
            4'd9:    seg_enc = 8'h90;
            default: seg_enc = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexes a packed BCD vector onto one digit at a
// time, with optional leading-zero blanking.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGITS   = 6,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4*DIGITS-1:0]   i_bcd,
    output logic [7:0]            o_seg_led,
    output logic [DIGITS-1:0]     o_seg_sel
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [7:0]        r_led;
    logic [DIGITS-1:0] r_sel;
    logic              w_wrap;
    logic [IW-1:0]     w_idx_next;
    logic [3:0]        w_digit;
    logic [DIGITS-1:0] w_blank;

    assign w_wrap     = r_cnt == CNT_LAST;
    assign w_idx_next = !w_wrap ? r_idx : (r_idx == IDX_LAST ? '0 : r_idx + 1'b1);
    assign w_digit    = i_bcd[4*w_idx_next +: 4];
    assign o_seg_led  = r_led;
    assign o_seg_sel  = r_sel;

    // Blank from the top down while every digit seen so far is zero; digit 0 always shows.
    always_comb begin
        logic v_z;
        w_blank = '0;
        v_z     = BLANK_LZ != 0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            v_z        = v_z && i_bcd[4*i +: 4] == 4'd0;
            w_blank[i] = v_z;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_led <= SEG_BLANK;
            r_sel <= ~DIGITS'(1);
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            r_idx <= w_idx_next;
            r_sel <= ~(DIGITS'(1) << w_idx_next);
            r_led <= w_blank[w_idx_next] ? SEG_BLANK : seg_enc(w_digit);
        end
    end

endmodule

// File: rtl/seg_bcd_counter.sv
// seg_bcd_counter: N-digit BCD up/down event counter with synchronised
// pulse input and a multiplexed seven-segment display driver.
module seg_bcd_counter
    import seg_pkg::*;
#(
    parameter int DIGITS   = 6,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                cnt_in,
    input  logic                up_dn,
    input  logic                clr,
    input  logic                hold,
    output logic [4*DIGITS-1:0] count_bcd,
    output logic                ovf,
    output logic [7:0]          seg_led,
    output logic [DIGITS-1:0]   seg_sel
);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_edge;
    logic [4*DIGITS-1:0] r_count;
    logic                r_ovf;
    logic                w_evt;
    logic                w_wrap;
    logic [4*DIGITS-1:0] w_next;

    assign w_evt     = r_sync2 & ~r_edge;
    assign count_bcd = r_count;
    assign ovf       = r_ovf;

    // Ripple carry/borrow: a digit steps only while every lower digit rolled over.
    always_comb begin
        logic       v_c;
        logic [3:0] v_d;
        w_next = r_count;
        v_c    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            v_d = r_count[4*i +: 4];
            if (v_c) begin
                w_next[4*i +: 4] = up_dn ? (v_d == BCD_MAX ? 4'd0 : v_d + 4'd1)
                                         : (v_d == 4'd0 ? BCD_MAX : v_d - 4'd1);
                v_c = up_dn ? v_d == BCD_MAX : v_d == 4'd0;
            end
        end
        w_wrap = v_c;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_edge  <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_sync1 <= cnt_in;
            r_sync2 <= r_sync1;
            r_edge  <= r_sync2;
            r_count <= clr ? '0 : (hold || !w_evt) ? r_count : w_next;
            r_ovf   <= !clr && !hold && w_evt && w_wrap;
        end
    end

    seg_scan_mux #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .BLANK_LZ (BLANK_LZ)
    ) u_scan (
        .i_clk     (sys_clk),
        .i_rst     (sys_rst),
        .i_bcd     (r_count),
        .o_seg_led (seg_led),
        .o_seg_sel (seg_sel)
    );

endmodule

// File: tb/tb_seg_bcd_counter.sv
// tb_seg_bcd_counter: directed checks of counting, wrap, clr/hold priority,
// input synchronisation, scan sequence, blanking and async reset.
module tb_seg_bcd_counter;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cnt_in  = 1'b0;
    logic        up_dn   = 1'b1;
    logic        clr     = 1'b0;
    logic        hold    = 1'b0;
    logic [15:0] count_bcd, count_nb;
    logic        ovf, ovf_nb;
    logic [7:0]  seg_led, seg_led_nb;
    logic [3:0]  seg_sel, seg_sel_nb;

    int n_vec = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    seg_bcd_counter #(.DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cnt_in(cnt_in), .up_dn(up_dn),
        .clr(clr), .hold(hold), .count_bcd(count_bcd), .ovf(ovf),
        .seg_led(seg_led), .seg_sel(seg_sel)
    );

    seg_bcd_counter #(.DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(0)) dut_nb (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cnt_in(cnt_in), .up_dn(up_dn),
        .clr(clr), .hold(hold), .count_bcd(count_nb), .ovf(ovf_nb),
        .seg_led(seg_led_nb), .seg_sel(seg_sel_nb)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic pulse();
        cnt_in = 1'b1;
        repeat (2) @(negedge sys_clk);
        cnt_in = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic pulse_obs(input logic up, input logic [15:0] prev, input logic [15:0] exp, input logic eo);
        up_dn  = up;
        cnt_in = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("lat_e2_cnt", count_bcd, prev);
        check("lat_e2_ovf", ovf, 0);
        cnt_in = 1'b0;
        @(negedge sys_clk);
        check("lat_e3_cnt", count_bcd, exp);
        check("lat_e3_ovf", ovf, eo);
        @(negedge sys_clk);
        check("ovf_1cyc", ovf, 0);
        @(negedge sys_clk);
        up_dn = 1'b1;
    endtask

    task automatic wait_sel(input logic [3:0] want, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 32 && !ok; i++) begin
            if (seg_sel == want) ok = 1'b1;
            else @(negedge sys_clk);
        end
    endtask

    logic       ok;
    logic [3:0] e_sel;
    logic [7:0] e_lz [4] = '{8'hA4, 8'hF9, 8'hFF, 8'hFF};
    logic [7:0] e_nb [4] = '{8'hA4, 8'hF9, 8'hC0, 8'hC0};

    initial begin
        repeat (3) @(negedge sys_clk);
        check("rst_cnt", count_bcd, 16'h0000);
        check("rst_ovf", ovf, 0);
        check("rst_led", seg_led, 8'hFF);
        check("rst_sel", seg_sel, 4'b1110);
        sys_rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            e_sel = ~(4'b0001 << ((k / 4) % 4));
            check("scan_seq", seg_sel, e_sel);
            @(negedge sys_clk);
        end

        repeat (12) pulse();
        check("up12", count_bcd, 16'h0012);
        check("up12_nb", count_nb, 16'h0012);
        for (int d = 0; d < 4; d++) begin
            e_sel = ~(4'b0001 << d);
            wait_sel(e_sel, ok);
            check("scan_found", ok, 1);
            check("led_lz", seg_led, e_lz[d]);
            check("led_nb", seg_led_nb, e_nb[d]);
        end

        clr = 1'b1;
        @(negedge sys_clk);
        clr = 1'b0;
        check("clr", count_bcd, 16'h0000);
        pulse_obs(1'b0, 16'h0000, 16'h9999, 1'b1);
        pulse_obs(1'b1, 16'h9999, 16'h0000, 1'b1);

        up_dn  = 1'b0;
        cnt_in = 1'b1;
        repeat (2) @(negedge sys_clk);
        clr    = 1'b1;
        cnt_in = 1'b0;
        @(negedge sys_clk);
        clr = 1'b0;
        check("clr_evt_cnt", count_bcd, 16'h0000);
        check("clr_evt_ovf", ovf, 0);
        @(negedge sys_clk);
        check("clr_evt_ovf2", ovf, 0);
        up_dn = 1'b1;
        repeat (2) @(negedge sys_clk);

        repeat (3) pulse();
        check("up3", count_bcd, 16'h0003);
        hold = 1'b1;
        repeat (5) pulse();
        check("hold_cnt", count_bcd, 16'h0003);
        check("hold_ovf", ovf, 0);
        hold = 1'b0;
        pulse();
        check("post_hold", count_bcd, 16'h0004);

        cnt_in = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("long_e2", count_bcd, 16'h0004);
        @(negedge sys_clk);
        check("long_e3", count_bcd, 16'h0005);
        repeat (17) @(negedge sys_clk);
        check("long_high", count_bcd, 16'h0005);
        cnt_in = 1'b0;
        repeat (4) @(negedge sys_clk);
        check("long_once", count_bcd, 16'h0005);

        for (int p = 0; p < 3; p++) begin
            cnt_in = 1'b1;
            @(negedge sys_clk);
            cnt_in = 1'b0;
            @(negedge sys_clk);
        end
        repeat (4) @(negedge sys_clk);
        check("fast3", count_bcd, 16'h0008);

        wait_sel(4'b1011, ok);
        check("mid_found", ok, 1);
        #2 sys_rst = 1'b1;
        #1;
        check("arst_sel", seg_sel, 4'b1110);
        check("arst_led", seg_led, 8'hFF);
        check("arst_cnt", count_bcd, 16'h0000);
        check("arst_nb_sel", seg_sel_nb, 4'b1110);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg_bcd_counter.md
# seg_bcd_counter

Parametrised N-digit BCD event counter with a multiplexed common-anode seven-segment driver. Counts synchronised rising edges of an external pulse up or down, with clear, hold, wrap/underflow indication and optional leading-zero blanking. It drives the board digit bank directly and is the general-purpose successor to the fixed 4-digit count display.

## Interface
- DIGITS, 6, number of BCD digits and display positions (1..8)
- SCAN_DIV, 50000, sys_clk cycles each digit stays selected (>= 2)
- BLANK_LZ, 1, 1 = blank leading zero digits; digit 0 is never blanked

Ports:
- sys_clk  in  1  single clock; all logic on rising edge
- sys_rst  in  1  asynchronous, active-high reset
- cnt_in  in  1  asynchronous event input; each rising edge is one event
- up_dn  in  1  1 = count up, 0 = count down; sampled on the event cycle
- clr  in  1  synchronous clear of the count
- hold  in  1  1 = ignore events; events are dropped, not queued
- count_bcd  out  4*DIGITS  packed BCD count; digit i = [4i+3:4i]
- ovf  out  1  one-cycle pulse on wrap 10^DIGITS-1→0 (up) or 0→10^DIGITS-1 (down)
- seg_led  out  8  active-low segments, bit7 = dp (always 1), bits6..0 = g..a
- seg_sel  out  DIGITS  active-low one-hot digit select; bit i = digit i (0 = LSD)

## Operation
- Reset values: count_bcd 0, ovf 0, seg_led 8'hFF, seg_sel all ones except bit0 = 0, scan counter 0, digit index 0, synchroniser flops 0.
- Input path: cnt_in → 2-flop synchroniser → edge flop; event = sync_q2 & ~edge_q.
- Count update priority per cycle: clr (count ← 0, ovf 0) > hold (no change) > event (±1 BCD) > none.
- Up: digit 9 → 0 and carry into next; all-9 → all-0 with ovf = 1.
- Down: digit 0 → 9 and borrow; all-0 → all-9 with ovf = 1.
- Digits never hold A–F; the count register is only reset, cleared or BCD-stepped.
- Scan: counter runs 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps and the index advances, wrapping DIGITS-1 → 0.
- Each cycle: seg_sel ← onehot_n(idx_next); seg_led ← enc(count_bcd[idx_next]) using the pre-edge count. seg_sel and seg_led are therefore always consistent.
- Encoding 0..9: C0 F9 A4 B0 99 92 82 F8 80 90.
- Blanking (BLANK_LZ = 1): digit i > 0 outputs 8'hFF when it and all higher digits are 0.

## Timing
- Event latency: cnt_in high at sampling edge E1 → count_bcd and ovf update on edge E3.
- Display latency: a count change is visible on seg_led 1 cycle later if that digit is selected.
- cnt_in held high for any duration produces exactly one event. Min high and low times are 2 cycles each for a guaranteed count.
- clr/hold act on the same edge they are sampled high; no pipeline.
- Simultaneous clr + wrapping event: count 0, ovf 0.
- sys_rst mid-operation: all outputs take reset values immediately (asynchronous); a pending event in the synchroniser is lost.
- Each digit is selected for exactly SCAN_DIV cycles; full frame = DIGITS*SCAN_DIV cycles.

## Structure
- Package seg_pkg: 7-seg encode function, SEG_BLANK = 8'hFF, BCD_MAX = 4'd9.
- Sub-module seg_scan_mux: scan counter, index, seg_sel/seg_led registers, blanking. Inputs are the packed BCD vector and the parameters.
- The top level holds the synchroniser, edge detect and BCD up/down counter.

## Test plan
Configuration: DIGITS = 4, SCAN_DIV = 4 unless stated.
- Reset, 12 up pulses → count_bcd = 16'h0012. Scan shows digit0 A4, digit1 F9, digits 2–3 FF. With BLANK_LZ = 0, digits 2–3 show C0.
- From 0, one down pulse → 16'h9999 with ovf high for exactly 1 cycle. Then one up pulse → 16'h0000 with ovf pulse.
- clr asserted on the event cycle → count 0, no ovf. hold = 1 across 5 pulses → count unchanged. hold released → next pulse counts.
- cnt_in high for 20 cycles → single increment, landing exactly on the 3rd edge after first sampling. 1-cycle-wide high pulses 2 cycles apart each count.
- seg_sel sequence 1110 ×4 cycles, 1101, 1011, 0111, then back to 1110. sys_rst asserted mid-frame → seg_sel = 1110, seg_led = FF, count 0 within the same cycle.
